avst_pkt_tx: RTL and testbench
==============================

AVST_PKT_TX -- requirements
Module: avst_pkt_tx

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter MAX_PKT_LEN, default 16, packet buffer depth in words (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port srst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port wr_data_i  input  DWIDTH  word to load into packet buffer.
REQ-006 SHALL have port wr_valid_i  input  1  wr_data_i valid.
REQ-007 SHALL have port wr_last_i  input  1  marks last word of packet.
REQ-008 SHALL have port wr_ready_o  output  1  buffer accepts a word this cycle.
REQ-009 SHALL have port src_data_o  output  DWIDTH  Avalon-ST source data.
REQ-010 SHALL have port src_startofpacket_o  output  1  first word of packet.
REQ-011 SHALL have port src_endofpacket_o  output  1  last word of packet.
REQ-012 SHALL have port src_valid_o  output  1  source word valid.
REQ-013 SHALL have port src_ready_i  input  1  downstream sink ready.

Function
REQ-014 SHALL be store-and-forward: the full packet is buffered before its first word is emitted.
REQ-015 SHALL implement FSM states LOAD, SEND; reset state LOAD.
REQ-016 LOAD: wr_ready_o=1; a word is accepted when wr_valid_i && wr_ready_o and is written at index wr_cnt, then wr_cnt increments.
REQ-017 LOAD->SEND on the cycle a word is accepted with wr_last_i=1, or when the accepted word is word MAX_PKT_LEN (forced end; wr_last_i ignored then).
REQ-018 SEND: wr_ready_o=0; wr_valid_i ignored.
REQ-019 All src_* outputs SHALL be registered; src_valid_o rises the cycle after the terminating write (latency 1).
REQ-020 A word is transferred when src_valid_o && src_ready_i; rd_cnt then advances to the next word on the next cycle.
REQ-021 While src_valid_o=1 and src_ready_i=0, src_data_o/sop/eop SHALL hold stable; src_valid_o SHALL not drop.
REQ-022 src_startofpacket_o=1 only on word 0; src_endofpacket_o=1 only on word len-1; single-word packet asserts both.
REQ-023 SEND->LOAD on transfer of the eop word; src_valid_o=0 and wr_ready_o=1 the following cycle (one bubble between packets).
REQ-024 src_ready_i is ignored while src_valid_o=0; no word is emitted without a preceding load.
REQ-025 Counters SHALL be $clog2(MAX_PKT_LEN+1) bits wide; no wrap within a packet.

Reset
REQ-026 srst=1 SHALL asynchronously force state LOAD, wr_cnt=0, rd_cnt=0, src_valid_o=0, src_startofpacket_o=0, src_endofpacket_o=0, src_data_o=0, wr_ready_o=1 (wr_ready_o=0 while srst is held).
REQ-027 Reset mid-LOAD or mid-SEND SHALL discard the partial packet; no residual words are emitted after release.
REQ-028 Buffer memory contents SHALL not require reset.

Configuration
REQ-029 Macro AVST_PKT_TX_STAT_EN defined: adds output tx_pkt_cnt_o (16 bits), reset 0, increments by 1 on each eop transfer, wraps 65535->0.
REQ-030 Macro AVST_PKT_TX_STAT_EN undefined: port tx_pkt_cnt_o and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-031 Load 4 words 0x11,0x22,0x33,0x44 (last on 0x44), src_ready_i=1 -> 4 consecutive beats, sop on 0x11, eop on 0x44, first beat 1 cycle after last write.
REQ-032 Load 1 word 0xA5 with last -> single beat 0xA5 with sop=eop=1.
REQ-033 Load 16 words 0..15 with wr_last_i=0 -> wr_ready_o drops after word 15; 16 beats emitted, eop on 15.
REQ-034 3-word packet, src_ready_i low 5 cycles during beat 2 -> beat 2 data/eop/sop held stable, valid stays 1, no loss.
REQ-035 Assert srst for 1 cycle during beat 2 of a 4-word SEND -> src_valid_o=0 immediately; next packet 0x7E,0x7F emitted correctly with sop on 0x7E.
REQ-036 With AVST_PKT_TX_STAT_EN, send 3 packets back to back -> tx_pkt_cnt_o=3, wr_ready_o low during every SEND.

Source files
------------

// File: rtl/avst_pkt_tx.sv
// rtl/avst_pkt_tx.sv - store-and-forward Avalon-ST packet transmitter
// Optional packet counter output tx_pkt_cnt_o when AVST_PKT_TX_STAT_EN is defined.
module avst_pkt_tx #(
  parameter int DWIDTH      = 8,
  parameter int MAX_PKT_LEN = 16
) (
  input  logic              clk,
  input  logic              srst,
  input  logic [DWIDTH-1:0] wr_data_i,
  input  logic              wr_valid_i,
  input  logic              wr_last_i,
  output logic              wr_ready_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              src_valid_o,
`ifdef AVST_PKT_TX_STAT_EN
  output logic [15:0]       tx_pkt_cnt_o,
`endif
  input  logic              src_ready_i
);

  localparam int CW = $clog2(MAX_PKT_LEN + 1);
  localparam int AW = $clog2(MAX_PKT_LEN);

  typedef enum logic {LOAD = 1'b0, SEND = 1'b1} state_t;

  state_t              state_q;
  logic [CW-1:0]       wr_cnt_q;
  logic [CW-1:0]       rd_cnt_q;
  logic [CW-1:0]       last_idx_q;
  logic                wr_ready_q;
  logic [DWIDTH-1:0]   src_data_q;
  logic                src_sop_q;
  logic                src_eop_q;
  logic                src_valid_q;
  logic [DWIDTH-1:0]   mem [MAX_PKT_LEN];

  logic                wr_fire;
  logic                wr_term;
  logic                rd_fire;
  logic [CW-1:0]       rd_cnt_d;

  assign wr_ready_o          = wr_ready_q & ~srst;
  assign src_data_o          = src_data_q;
  assign src_startofpacket_o = src_sop_q;
  assign src_endofpacket_o   = src_eop_q;
  assign src_valid_o         = src_valid_q;

  assign wr_fire  = wr_valid_i && wr_ready_o;
  assign wr_term  = wr_fire && (wr_last_i || (wr_cnt_q == CW'(MAX_PKT_LEN - 1)));
  assign rd_fire  = src_valid_q && src_ready_i;
  assign rd_cnt_d = rd_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_cnt_q[AW-1:0]] <= wr_data_i;
    end
  end

`ifdef AVST_PKT_TX_STAT_EN
  logic [15:0] tx_pkt_cnt_q;
  assign tx_pkt_cnt_o = tx_pkt_cnt_q;

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      tx_pkt_cnt_q <= '0;
    end else if (rd_fire && src_eop_q) begin
      tx_pkt_cnt_q <= tx_pkt_cnt_q + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q     <= LOAD;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      last_idx_q  <= '0;
      wr_ready_q  <= 1'b1;
      src_data_q  <= '0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
      src_valid_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (wr_fire) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
          end
          // Word 0 of a one-word packet is still on the write port, not in memory yet.
          if (wr_term) begin
            state_q     <= SEND;
            wr_ready_q  <= 1'b0;
            last_idx_q  <= wr_cnt_q;
            rd_cnt_q    <= '0;
            src_valid_q <= 1'b1;
            src_sop_q   <= 1'b1;
            src_eop_q   <= (wr_cnt_q == '0);
            src_data_q  <= (wr_cnt_q == '0) ? wr_data_i : mem[0];
          end
        end
        SEND: begin
          if (rd_fire) begin
            if (src_eop_q) begin
              state_q     <= LOAD;
              wr_ready_q  <= 1'b1;
              wr_cnt_q    <= '0;
              rd_cnt_q    <= '0;
              src_valid_q <= 1'b0;
              src_sop_q   <= 1'b0;
              src_eop_q   <= 1'b0;
            end else begin
              rd_cnt_q   <= rd_cnt_d;
              src_data_q <= mem[rd_cnt_d[AW-1:0]];
              src_sop_q  <= 1'b0;
              src_eop_q  <= (rd_cnt_d == last_idx_q);
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_avst_pkt_tx.sv
// tb/tb_avst_pkt_tx.sv - self-checking bench for avst_pkt_tx
// Define AVST_PKT_TX_STAT_EN for both files to exercise the packet counter.
module tb_avst_pkt_tx;
  localparam int DW = 8;
  localparam int ML = 16;

  logic          clk = 1'b0;
  logic          srst;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_last;
  logic          wr_ready;
  logic [DW-1:0] src_data;
  logic          src_sop;
  logic          src_eop;
  logic          src_valid;
  logic          src_ready;
`ifdef AVST_PKT_TX_STAT_EN
  logic [15:0]   tx_pkt_cnt;
`endif

  avst_pkt_tx #(.DWIDTH(DW), .MAX_PKT_LEN(ML)) dut (
    .clk                 (clk),
    .srst                (srst),
    .wr_data_i           (wr_data),
    .wr_valid_i          (wr_valid),
    .wr_last_i           (wr_last),
    .wr_ready_o          (wr_ready),
    .src_data_o          (src_data),
    .src_startofpacket_o (src_sop),
    .src_endofpacket_o   (src_eop),
    .src_valid_o         (src_valid),
`ifdef AVST_PKT_TX_STAT_EN
    .tx_pkt_cnt_o        (tx_pkt_cnt),
`endif
    .src_ready_i         (src_ready)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: packets are lists of words, the sink sees them as a queue of beats.
  typedef struct {logic [DW-1:0] d; logic sop; logic eop;} beat_t;
  beat_t         exp_q[$];
  logic [DW-1:0] acc_q[$];
  bit            m_load = 1'b1;
  int            m_pkts = 0;

  always @(posedge clk or posedge srst) begin
    if (srst) begin
      exp_q.delete();
      acc_q.delete();
      m_load = 1'b1;
      m_pkts = 0;
    end else if (m_load) begin
      if (wr_valid) begin
        acc_q.push_back(wr_data);
        if (wr_last || acc_q.size() == ML) begin
          for (int i = 0; i < acc_q.size(); i++) begin
            beat_t b;
            b.d   = acc_q[i];
            b.sop = (i == 0);
            b.eop = (i == acc_q.size() - 1);
            exp_q.push_back(b);
          end
          acc_q.delete();
          m_load = 1'b0;
        end
      end
    end else if (src_ready) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        m_load = 1'b1;
        m_pkts = m_pkts + 1;
      end
    end
  end

  typedef struct {logic [DW-1:0] d; logic sop; logic eop; int cyc;} log_t;
  log_t lg[$];
  int   first_valid_cyc = -1;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    logic exp_v;
    exp_v = !srst && !m_load;
    chk("wr_ready", wr_ready, !srst && m_load);
    chk("src_valid", src_valid, exp_v);
    if (exp_v && exp_q.size() > 0) begin
      chk("src_data", src_data, exp_q[0].d);
      chk("src_sop", src_sop, exp_q[0].sop);
      chk("src_eop", src_eop, exp_q[0].eop);
    end
`ifdef AVST_PKT_TX_STAT_EN
    chk("tx_pkt_cnt", tx_pkt_cnt, m_pkts[15:0]);
`endif
    if (src_valid && src_ready) begin
      log_t e;
      e.d = src_data; e.sop = src_sop; e.eop = src_eop; e.cyc = cyc;
      lg.push_back(e);
    end
    if (src_valid && !prev_valid) first_valid_cyc = cyc;
    prev_valid = src_valid;
  end

  logic [DW-1:0] pkt_w[$];
  int            last_drive_cyc;

  task automatic wait_load();
    int n = 0;
    while (!m_load && n < 300) begin
      @(posedge clk) #2;
      n++;
    end
    if (!m_load) chk("wait_load_timeout", 0, 1);
  endtask

  task automatic send_pkt(input bit use_last);
    wait_load();
    for (int i = 0; i < pkt_w.size(); i++) begin
      wr_valid       = 1'b1;
      wr_data        = pkt_w[i];
      wr_last        = use_last && (i == pkt_w.size() - 1);
      last_drive_cyc = cyc;
      @(posedge clk) #2;
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic wait_beats_left(input int n);
    int k = 0;
    while (exp_q.size() != n && k < 300) begin
      @(posedge clk) #2;
      k++;
    end
    if (exp_q.size() != n) chk("wait_beats_timeout", 0, 1);
  endtask

  task automatic pulse_reset();
    srst = 1'b1;
    @(posedge clk) #2;
    srst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    srst = 1'b1; wr_valid = 1'b0; wr_last = 1'b0; wr_data = '0; src_ready = 1'b1;
    @(posedge clk) #2;
    chk("rst_held_wr_ready", wr_ready, 0);
    @(posedge clk) #2;
    srst = 1'b0;
    #1;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_src_valid", src_valid, 0);
    chk("rst_src_data", src_data, 0);
    chk("rst_sop_eop", {src_sop, src_eop}, 0);
    @(posedge clk) #1;

    // 4-word packet, sink always ready
    lg.delete();
    pkt_w = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(1'b1);
    wait_beats_left(0); wait_load();
    chk("t1_beats", lg.size(), 4);
    if (lg.size() == 4) begin
      chk("t1_b0", {lg[0].d, lg[0].sop, lg[0].eop}, {8'h11, 2'b10});
      chk("t1_b3", {lg[3].d, lg[3].sop, lg[3].eop}, {8'h44, 2'b01});
      chk("t1_back_to_back", lg[3].cyc - lg[0].cyc, 3);
    end
    chk("t1_latency", first_valid_cyc, last_drive_cyc + 1);

    // single-word packet
    lg.delete();
    pkt_w = '{8'hA5};
    send_pkt(1'b1);
    wait_load();
    chk("t2_beats", lg.size(), 1);
    if (lg.size() == 1) chk("t2_b0", {lg[0].d, lg[0].sop, lg[0].eop}, {8'hA5, 2'b11});
    chk("t2_latency", first_valid_cyc, last_drive_cyc + 1);

    // full buffer without wr_last: forced end
    lg.delete();
    pkt_w.delete();
    for (int i = 0; i < ML; i++) pkt_w.push_back(8'(i));
    send_pkt(1'b0);
    wait_load();
    chk("t3_beats", lg.size(), 16);
    if (lg.size() == 16) begin
      chk("t3_b15", {lg[15].d, lg[15].sop, lg[15].eop}, {8'h0F, 2'b01});
      chk("t3_b14_eop", lg[14].eop, 0);
      chk("t3_b0", {lg[0].d, lg[0].sop}, {8'h00, 1'b1});
    end

    // backpressure for 5 cycles on beat 2
    lg.delete();
    pkt_w = '{8'h31, 8'h32, 8'h33};
    send_pkt(1'b1);
    wait_beats_left(2);
    src_ready = 1'b0;
    repeat (5) @(posedge clk) #2;
    src_ready = 1'b1;
    wait_load();
    chk("t4_beats", lg.size(), 3);
    if (lg.size() == 3) begin
      chk("t4_b1", {lg[1].d, lg[1].sop, lg[1].eop}, {8'h32, 2'b00});
      chk("t4_stall_gap", lg[1].cyc - lg[0].cyc, 6);
      chk("t4_b2", {lg[2].d, lg[2].eop}, {8'h33, 1'b1});
    end

    // reset during beat 2 of a 4-word packet
    pkt_w = '{8'h51, 8'h52, 8'h53, 8'h54};
    send_pkt(1'b1);
    wait_beats_left(3);
    srst = 1'b1;
    #1;
    chk("t5_rst_valid", src_valid, 0);
    chk("t5_rst_ready", wr_ready, 0);
    @(posedge clk) #2;
    srst = 1'b0;
    lg.delete();
    pkt_w = '{8'h7E, 8'h7F};
    send_pkt(1'b1);
    wait_load();
    chk("t5_beats", lg.size(), 2);
    if (lg.size() == 2) begin
      chk("t5_b0", {lg[0].d, lg[0].sop, lg[0].eop}, {8'h7E, 2'b10});
      chk("t5_b1", {lg[1].d, lg[1].sop, lg[1].eop}, {8'h7F, 2'b01});
    end

    // three packets back to back from a fresh counter
    pulse_reset();
    lg.delete();
    pkt_w = '{8'h01, 8'h02};       send_pkt(1'b1);
    pkt_w = '{8'h03};              send_pkt(1'b1);
    pkt_w = '{8'h04, 8'h05, 8'h06}; send_pkt(1'b1);
    wait_load();
    chk("t6_model_pkts", m_pkts, 3);
    chk("t6_beats", lg.size(), 6);
    if (lg.size() == 6) chk("t6_b5", {lg[5].d, lg[5].eop}, {8'h06, 1'b1});
`ifdef AVST_PKT_TX_STAT_EN
    #1;
    chk("t6_tx_pkt_cnt", tx_pkt_cnt, 3);
`endif

    @(posedge clk) #2;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
